// File: rtl/signed_dec_display.sv
// Signed two's-complement result display.
// A captured sum is converted to decimal with shift-and-add-3, then shown on a
// four-digit multiplexed seven-segment display: sign, hundreds, tens, ones.
module signed_dec_display #(
    parameter int WIDTH       = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             overflow,
    output logic             busy,
    output logic [3:0]       an,
    output logic [6:0]       seg,
    output logic             dp
);

    localparam int            PW         = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [3:0]    CONV_LAST  = 4'(WIDTH - 1);

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mag, mag_nxt;
    logic             sign, sign_nxt;
    logic             ovf, ovf_nxt;
    logic [11:0]      bcd, bcd_nxt;
    logic [11:0]      adj;
    logic [3:0]       cnt, cnt_nxt;
    logic             load_digits;

    logic [PW-1:0]    presc, presc_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [6:0]       digit [4];
    logic [6:0]       digit_nxt [4];

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'b1000000;
            4'd1:    enc = 7'b1111001;
            4'd2:    enc = 7'b0100100;
            4'd3:    enc = 7'b0110000;
            4'd4:    enc = 7'b0011001;
            4'd5:    enc = 7'b0010010;
            4'd6:    enc = 7'b0000010;
            4'd7:    enc = 7'b1111000;
            4'd8:    enc = 7'b0000000;
            4'd9:    enc = 7'b0010000;
            default: enc = 7'b1111111;
        endcase
    endfunction

    function automatic logic [3:0] add3(input logic [3:0] n);
        add3 = (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    assign busy = (state != IDLE);
    assign dp   = 1'b1;

    // Conversion FSM: capture in IDLE, WIDTH double-dabble steps in CONV, publish in DONE.
    always_comb begin
        state_nxt   = state;
        mag_nxt     = mag;
        sign_nxt    = sign;
        ovf_nxt     = ovf;
        bcd_nxt     = bcd;
        cnt_nxt     = cnt;
        adj         = '0;
        load_digits = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    mag_nxt   = value[WIDTH-1] ? (~value + 1'b1) : value;
                    sign_nxt  = value[WIDTH-1];
                    ovf_nxt   = overflow;
                    bcd_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                adj     = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
                bcd_nxt = (adj << 1) | {11'd0, mag[WIDTH-1]};
                mag_nxt = mag << 1;
                cnt_nxt = cnt + 4'd1;
                if (cnt == CONV_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                load_digits = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Conversion state registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mag   <= '0;
            sign  <= 1'b0;
            ovf   <= 1'b0;
            bcd   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            mag   <= mag_nxt;
            sign  <= sign_nxt;
            ovf   <= ovf_nxt;
            bcd   <= bcd_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next digit patterns (with leading-zero blanking) and scan position.
    always_comb begin
        digit_nxt = digit;
        presc_nxt = presc + PW'(1);
        idx_nxt   = idx;
        if (load_digits) begin
            digit_nxt[0] = enc(bcd[3:0]);
            digit_nxt[1] = (bcd[11:4] == 8'd0) ? SEG_BLANK : enc(bcd[7:4]);
            digit_nxt[2] = (bcd[11:8] == 4'd0) ? SEG_BLANK : enc(bcd[11:8]);
            digit_nxt[3] = ovf ? SEG_E : (sign ? SEG_DASH : SEG_BLANK);
        end
        if (presc == PRESC_LAST) begin
            presc_nxt = '0;
            idx_nxt   = idx + 2'd1;
        end
    end

    // Display registers; an and seg are both derived from next-state values so they switch together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit[0] <= SEG_0;
            digit[1] <= SEG_BLANK;
            digit[2] <= SEG_BLANK;
            digit[3] <= SEG_BLANK;
            presc    <= '0;
            idx      <= '0;
            an       <= 4'b1110;
            seg      <= SEG_0;
        end else begin
            digit <= digit_nxt;
            presc <= presc_nxt;
            idx   <= idx_nxt;
            an    <= ~(4'b0001 << idx_nxt);
            seg   <= digit_nxt[idx_nxt];
        end
    end

endmodule

// File: tb/tb_signed_dec_display.sv
// Scoreboard bench for signed_dec_display: a 4-bit and a 10-bit instance, both fast-scanning.
module tb_signed_dec_display;

    localparam logic [6:0] SEG0  = 7'b1000000;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       loadA, ovfA, busyA, dpA;
    logic [3:0] valueA, anA;
    logic [6:0] segA;
    logic       loadB, ovfB, busyB, dpB;
    logic [9:0] valueB;
    logic [3:0] anB;
    logic [6:0] segB;

    int total = 0;
    int bad   = 0;
    logic [27:0] sb [$];

    signed_dec_display #(.WIDTH(4), .REFRESH_DIV(4)) dutA (
        .clk(clk), .rst_n(rst_n), .load(loadA), .value(valueA), .overflow(ovfA),
        .busy(busyA), .an(anA), .seg(segA), .dp(dpA)
    );

    signed_dec_display #(.WIDTH(10), .REFRESH_DIV(4)) dutB (
        .clk(clk), .rst_n(rst_n), .load(loadB), .value(valueB), .overflow(ovfB),
        .busy(busyB), .an(anB), .seg(segB), .dp(dpB)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] segOf(input int d);
        case (d)
            0:       segOf = 7'b1000000;
            1:       segOf = 7'b1111001;
            2:       segOf = 7'b0100100;
            3:       segOf = 7'b0110000;
            4:       segOf = 7'b0011001;
            5:       segOf = 7'b0010010;
            6:       segOf = 7'b0000010;
            7:       segOf = 7'b1111000;
            8:       segOf = 7'b0000000;
            9:       segOf = 7'b0010000;
            10:      segOf = 7'b0111111;
            11:      segOf = 7'b0000110;
            default: segOf = 7'b1111111;
        endcase
    endfunction

    // Expected {sign, hundreds, tens, ones} patterns from plain integer arithmetic.
    function automatic logic [27:0] expected(input int w, input int val, input bit ovf);
        int v, mag, h, t, o;
        bit neg;
        logic [6:0] s, hs, ts;
        v = val & ((1 << w) - 1);
        if (v >= (1 << (w - 1))) v = v - (1 << w);
        neg = (v < 0);
        mag = neg ? -v : v;
        h = mag / 100;
        t = (mag / 10) % 10;
        o = mag % 10;
        s  = ovf ? segOf(11) : (neg ? segOf(10) : BLANK);
        hs = (h == 0) ? BLANK : segOf(h);
        ts = (h == 0 && t == 0) ? BLANK : segOf(t);
        return {s, hs, ts, segOf(o)};
    endfunction

    function automatic logic busyOf(input int sel);
        return (sel != 0) ? busyB : busyA;
    endfunction

    // Called at a falling edge; strobes load for one cycle and returns one falling edge later.
    task automatic applyStimulus(input int sel, input int val, input bit ovf, input bit accept);
        if (sel != 0) begin
            loadB = 1'b1; valueB = 10'(val); ovfB = ovf;
        end else begin
            loadA = 1'b1; valueA = 4'(val); ovfA = ovf;
        end
        if (accept) sb.push_back(expected((sel != 0) ? 10 : 4, val, ovf));
        @(negedge clk);
        loadA = 1'b0;
        loadB = 1'b0;
    endtask

    task automatic waitDone(input int sel, input bit checkLen);
        int n;
        n = 0;
        while (busyOf(sel) && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (checkLen) checkOutput("busyLen", n, (sel != 0) ? 11 : 5);
        else          checkOutput("busyEnd", busyOf(sel), 0);
    endtask

    task automatic readDigits(input int sel, output logic [27:0] obs);
        logic [3:0] a;
        logic [6:0] s;
        int oneHotErr;
        obs = 'x;
        oneHotErr = 0;
        for (int k = 0; k < 20; k++) begin
            a = (sel != 0) ? anB : anA;
            s = (sel != 0) ? segB : segA;
            case (a)
                4'b1110: obs[6:0]   = s;
                4'b1101: obs[13:7]  = s;
                4'b1011: obs[20:14] = s;
                4'b0111: obs[27:21] = s;
                default: oneHotErr++;
            endcase
            @(negedge clk);
        end
        checkOutput("anOneHot", oneHotErr, 0);
    endtask

    task automatic compareTop(input int sel);
        logic [27:0] obs, expv;
        readDigits(sel, obs);
        if (sb.size() == 0) begin
            checkOutput("sbEmpty", 1, 0);
        end else begin
            expv = sb.pop_front();
            checkOutput("digits", obs, expv);
        end
        checkOutput("dp", (sel != 0) ? dpB : dpA, 1);
    endtask

    task automatic convert(input int sel, input int val, input bit ovf);
        applyStimulus(sel, val, ovf, 1'b1);
        waitDone(sel, 1'b1);
        compareTop(sel);
    endtask

    // Main sequence.
    initial begin
        logic [3:0]  e;
        logic [27:0] obs;
        rst_n = 1'b0;
        loadA = 1'b0; valueA = '0; ovfA = 1'b0;
        loadB = 1'b0; valueB = '0; ovfB = 1'b0;
        #12;
        checkOutput("rstAn",   anA,   4'b1110);
        checkOutput("rstSeg",  segA,  SEG0);
        checkOutput("rstBusy", busyA, 0);
        checkOutput("rstDp",   dpA,   1);
        checkOutput("rstAnB",  anB,   4'b1110);

        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            e = ~(4'b0001 << ((k / 4) % 4));
            checkOutput("scanAn",  anA,  e);
            checkOutput("scanSeg", segA, (((k / 4) % 4) == 0) ? SEG0 : BLANK);
            @(negedge clk);
        end

        convert(0, 8, 1'b0);
        convert(0, 7, 1'b1);
        convert(0, 0, 1'b0);
        convert(0, 15, 1'b0);
        convert(0, 5, 1'b0);

        applyStimulus(0, 3, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(0, 5, 1'b0, 1'b0);
        waitDone(0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("ignoredLoad", busyA, 0);
        compareTop(0);

        convert(1, 512, 1'b0);
        convert(1, 7, 1'b0);
        convert(1, 99, 1'b0);
        convert(1, 1014, 1'b0);
        convert(1, 511, 1'b1);

        applyStimulus(0, 8, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abortAn",   anA,   4'b1110);
        checkOutput("abortSeg",  segA,  SEG0);
        checkOutput("abortBusy", busyA, 0);
        checkOutput("abortDp",   dpA,   1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        readDigits(0, obs);
        checkOutput("abortDigits", obs, {BLANK, BLANK, BLANK, SEG0});
        checkOutput("abortIdle", busyA, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
